// File: rtl/hfu_pkg.sv
// Shared sizing defaults and pipeline tag types for the hazard/forwarding unit.
package hfu_pkg;

  localparam int DATA_W     = 16;
  localparam int RA_W       = 3;
  localparam int DEPTH      = 3;
  localparam int NOFWD_ADDR = 7;

  // rd field is sized for the widest supported register address; narrower addresses are zero-extended.
  localparam int RA_MAX = 8;

  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rd;
    logic              we;
  } hfu_entry_t;

  localparam hfu_entry_t ENTRY_BUBBLE = '{valid: 1'b0, rd: 8'h00, we: 1'b0};

  function automatic logic entry_hits(input hfu_entry_t e, input logic [RA_MAX-1:0] addr);
    return e.valid & e.we & (e.rd == addr);
  endfunction

endpackage

// File: rtl/hfu_match.sv
// Per-source producer match: youngest matching stage wins, then forward or stall.
// Forwarding is compiled in only when HFU_FWD_EN is defined.
module hfu_match
  import hfu_pkg::*;
#(
  parameter int DATA_W     = hfu_pkg::DATA_W,
  parameter int RA_W       = hfu_pkg::RA_W,
  parameter int DEPTH      = hfu_pkg::DEPTH,
  parameter int NOFWD_ADDR = hfu_pkg::NOFWD_ADDR
) (
  input  hfu_entry_t [DEPTH-1:0]        entries,
  input  logic [RA_W-1:0]               src_addr,
  input  logic                          src_used,
  input  logic [DATA_W-1:0]             src_regdata,
  input  logic [DEPTH*DATA_W-1:0]       stg_data,
  input  logic [DEPTH-1:0]              stg_data_ok,
  output logic [DATA_W-1:0]             opr,
  output logic                          hit,
  output logic                          stall_req
);

  localparam logic [RA_W-1:0] NOFWD = RA_W'(NOFWD_ADDR);

  logic              eligible_s;
  logic              found_s;
  logic              win_ok_s;
  logic [DATA_W-1:0] win_data_s;

  assign eligible_s = src_used & (src_addr != NOFWD);

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    found_s    = 1'b0;
    win_ok_s   = 1'b0;
    win_data_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible_s && entry_hits(entries[i], RA_MAX'(src_addr))) begin
        found_s    = 1'b1;
        win_ok_s   = stg_data_ok[i];
        win_data_s = stg_data[i*DATA_W +: DATA_W];
      end else begin
        found_s    = found_s;
      end
    end
  end

`ifdef HFU_FWD_EN
  assign hit       = found_s & win_ok_s;
  assign stall_req = found_s & ~win_ok_s;
  assign opr       = hit ? win_data_s : src_regdata;
`else
  logic unused_s;
  assign unused_s  = ^{win_ok_s, win_data_s};
  assign hit       = 1'b0;
  assign stall_req = found_s;
  assign opr       = src_regdata;
`endif

endmodule

// File: rtl/hazard_fwd_unit.sv
// Producer-tag pipeline with operand forwarding / interlock and a saturating stall counter.
// Define HFU_FWD_EN to enable forwarding; otherwise every dependency stalls.
module hazard_fwd_unit
  import hfu_pkg::*;
#(
  parameter int DATA_W     = hfu_pkg::DATA_W,
  parameter int RA_W       = hfu_pkg::RA_W,
  parameter int DEPTH      = hfu_pkg::DEPTH,
  parameter int NOFWD_ADDR = hfu_pkg::NOFWD_ADDR
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    issue_valid,
  input  logic [RA_W-1:0]         issue_rd,
  input  logic                    issue_we,
  input  logic                    flush,
  input  logic [RA_W-1:0]         src1_addr,
  input  logic [RA_W-1:0]         src2_addr,
  input  logic                    src1_used,
  input  logic                    src2_used,
  input  logic [DATA_W-1:0]       src1_regdata,
  input  logic [DATA_W-1:0]       src2_regdata,
  input  logic [DEPTH*DATA_W-1:0] stg_data,
  input  logic [DEPTH-1:0]        stg_data_ok,
  output logic [DATA_W-1:0]       opr1,
  output logic [DATA_W-1:0]       opr2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic                    stall,
  output logic [15:0]             stall_cnt
);

  hfu_entry_t [DEPTH-1:0] entries_q;
  hfu_entry_t [DEPTH-1:0] entries_d;
  logic [15:0]            stall_cnt_q;
  logic [15:0]            stall_cnt_d;
  logic                   stall1_s;
  logic                   stall2_s;
  logic                   stall_s;

  hfu_match #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .NOFWD_ADDR(NOFWD_ADDR)) u_match1 (
    .entries     (entries_q),
    .src_addr    (src1_addr),
    .src_used    (src1_used),
    .src_regdata (src1_regdata),
    .stg_data    (stg_data),
    .stg_data_ok (stg_data_ok),
    .opr         (opr1),
    .hit         (fwd1_hit),
    .stall_req   (stall1_s)
  );

  hfu_match #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .NOFWD_ADDR(NOFWD_ADDR)) u_match2 (
    .entries     (entries_q),
    .src_addr    (src2_addr),
    .src_used    (src2_used),
    .src_regdata (src2_regdata),
    .stg_data    (stg_data),
    .stg_data_ok (stg_data_ok),
    .opr         (opr2),
    .hit         (fwd2_hit),
    .stall_req   (stall2_s)
  );

  assign stall_s   = stall1_s | stall2_s;
  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_q;

  // Older tags always advance; stage 0 takes the issue only when neither stalled nor flushed.
  always_comb begin
    entries_d = entries_q;
    for (int i = 1; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i-1];
    end
    if (issue_valid && !stall_s && !flush) begin
      entries_d[0] = '{valid: 1'b1, rd: RA_MAX'(issue_rd), we: issue_we};
    end else begin
      entries_d[0] = ENTRY_BUBBLE;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries_q   <= '0;
      stall_cnt_q <= 16'h0000;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
